cordic_quadrant_prerotate: RTL

// Front-end stage of the pipelined CORDIC rotator, directly upstream of the first iteration_rot stage.

---
 rtl/cordic_quadrant_prerotate_if.sv | 29 ++
 rtl/cordic_quadrant_prerotate.sv | 106 ++++++++++
 2 files changed

// File: rtl/cordic_quadrant_prerotate_if.sv
// Sample bus of the CORDIC quadrant pre-rotation stage.
// The upstream source drives the inputs and the iteration chain consumes the outputs.
interface cordic_quadrant_prerotate_if #(
  parameter int N = 31,
  parameter int M = 31
);
  logic              in_valid;
  logic signed [N:0] x_in;
  logic signed [N:0] y_in;
  logic        [M:0] angle_in;

  logic              out_valid;
  logic signed [N:0] x_out;
  logic signed [N:0] y_out;
  logic        [M:0] angle_out;
  logic        [M:0] dec_seed_out;
  logic        [1:0] quad_out;
  logic              sat_out;

  modport master (
    output in_valid, x_in, y_in, angle_in,
    input  out_valid, x_out, y_out, angle_out, dec_seed_out, quad_out, sat_out
  );

  modport slave (
    input  in_valid, x_in, y_in, angle_in,
    output out_valid, x_out, y_out, angle_out, dec_seed_out, quad_out, sat_out
  );
endinterface

// File: rtl/cordic_quadrant_prerotate.sv
// CORDIC front end: splits a binary angle into quadrant and first-quadrant residual,
// then rotates (x,y) by quadrant*90 deg with saturating negation. Two registered stages.
module cordic_quadrant_prerotate #(
  parameter int N = 31,
  parameter int M = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  cordic_quadrant_prerotate_if.slave bus
);

  localparam logic signed [N:0] MIN_VAL = {1'b1, {N{1'b0}}};
  localparam logic signed [N:0] MAX_VAL = {1'b0, {N{1'b1}}};

  // Stage 1: captured sample split into quadrant and residual
  logic signed [N:0] x1_q, y1_q;
  logic        [1:0] q1_q;
  logic        [M:0] res1_q;
  logic              v1_q;

  // Stage 2: rotated sample presented downstream
  logic signed [N:0] x2_q, y2_q;
  logic signed [N:0] x2_d, y2_d;
  logic        [1:0] q2_q;
  logic        [M:0] res2_q;
  logic              sat2_q, sat2_d;
  logic              v2_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q   <= '0;
      y1_q   <= '0;
      q1_q   <= '0;
      res1_q <= '0;
      v1_q   <= 1'b0;
    end else if (en) begin
      x1_q   <= bus.x_in;
      y1_q   <= bus.y_in;
      q1_q   <= bus.angle_in[M:M-1];
      res1_q <= {2'b00, bus.angle_in[M-2:0]};
      v1_q   <= bus.in_valid;
    end
  end

  logic signed [N:0] neg_x, neg_y;
  logic              x_is_min, y_is_min;

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    x_is_min = (x1_q == MIN_VAL);
    y_is_min = (y1_q == MIN_VAL);
    // The most negative value has no positive twin; clamp it to the largest positive.
    neg_x    = x_is_min ? MAX_VAL : -x1_q;
    neg_y    = y_is_min ? MAX_VAL : -y1_q;
    x2_d     = x1_q;
    y2_d     = y1_q;
    sat2_d   = 1'b0;
    case (q1_q)
      2'd1: begin
        x2_d   = neg_y;
        y2_d   = x1_q;
        sat2_d = y_is_min;
      end
      2'd2: begin
        x2_d   = neg_x;
        y2_d   = neg_y;
        sat2_d = x_is_min | y_is_min;
      end
      2'd3: begin
        x2_d   = y1_q;
        y2_d   = neg_x;
        sat2_d = x_is_min;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_q   <= '0;
      y2_q   <= '0;
      q2_q   <= '0;
      res2_q <= '0;
      sat2_q <= 1'b0;
      v2_q   <= 1'b0;
    end else if (en) begin
      x2_q   <= x2_d;
      y2_q   <= y2_d;
      q2_q   <= q1_q;
      res2_q <= res1_q;
      sat2_q <= sat2_d;
      v2_q   <= v1_q;
    end
  end

  assign bus.out_valid    = v2_q;
  assign bus.x_out        = x2_q;
  assign bus.y_out        = y2_q;
  assign bus.angle_out    = res2_q;
  assign bus.dec_seed_out = '0;
  assign bus.quad_out     = q2_q;
  assign bus.sat_out      = sat2_q;

endmodule
